// File: rtl/mem_port_sched.sv
// -----------------------------------------------------------------------------
// mem_port_sched
//
// Single-port synchronous RAM scheduler shared by an instruction fetch port
// (which reads an instruction pair) and two load/store slots of a dual-issue
// pipeline. Only one RAM access, or one two-word fetch burst, is in flight at
// any time.
//
// Grant priority in IDLE is ls0 > ls1 > fetch. A fairness counter lets the
// fetch port win once FAIR_MAX data grants have gone by while it was waiting.
//
// Ports
//   clk, reset           clock and synchronous active-high reset
//   if_req/if_addr       fetch request and address of the slot-0 instruction
//   if_done              one-cycle pulse; if_insn0/if_insn1 hold the pair
//   lsN_req/we/addr/wdata  load/store request of slot N (N = 0, 1)
//   lsN_done/lsN_rdata   completion pulse and load data of slot N
//   mem_addr/mem_write/mem_wdata  registered RAM command
//   mem_rdata            RAM read data, valid one cycle after the address
//   pipe_stall           data-side stall to the pipeline
// -----------------------------------------------------------------------------
module mem_port_sched #(
  parameter int AW       = 9,
  parameter int DW       = 16,
  parameter int FAIR_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_insn0,
  output logic [DW-1:0] if_insn1,
  input  logic          ls0_req,
  input  logic          ls0_we,
  input  logic [AW-1:0] ls0_addr,
  input  logic [DW-1:0] ls0_wdata,
  output logic          ls0_done,
  output logic [DW-1:0] ls0_rdata,
  input  logic          ls1_req,
  input  logic          ls1_we,
  input  logic [AW-1:0] ls1_addr,
  input  logic [DW-1:0] ls1_wdata,
  output logic          ls1_done,
  output logic [DW-1:0] ls1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_write,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          pipe_stall
);

  localparam int CW = (FAIR_MAX < 1) ? 1 : $clog2(FAIR_MAX + 1);
  localparam logic [CW-1:0] FAIR_LIMIT = CW'(FAIR_MAX);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC  = 3'd1,
    RESP = 3'd2,
    F0   = 3'd3,
    F1   = 3'd4,
    F2   = 3'd5
  } state_t;

  state_t        state_q;
  logic [CW-1:0] fair_cnt_q;
  logic [CW-1:0] fair_cnt_d;
  logic          slot_q;        // granted data slot: 0 = ls0, 1 = ls1
  logic [AW-1:0] mem_addr_q;
  logic          mem_write_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] if_insn0_q;
  logic          ls0_done_q;
  logic          ls1_done_q;
  logic          if_done_q;

  logic          fair_hit;
  logic          grant_if;
  logic          grant_ls0;
  logic          grant_ls1;
  logic          grant_data;

  // Grant decision, evaluated only while IDLE. ls1 can only win when ls0 is
  // not requesting, which keeps the two slots in program order.
  always_comb begin
    fair_hit  = (fair_cnt_q == FAIR_LIMIT);
    grant_if  = 1'b0;
    grant_ls0 = 1'b0;
    grant_ls1 = 1'b0;
    if (state_q == IDLE) begin
      if (if_req && fair_hit) begin
        grant_if = 1'b1;
      end else if (ls0_req) begin
        grant_ls0 = 1'b1;
      end else if (ls1_req) begin
        grant_ls1 = 1'b1;
      end else if (if_req) begin
        grant_if = 1'b1;
      end
    end
    grant_data = grant_ls0 | grant_ls1;
  end

  // The counter only measures how long the current fetch request has been
  // passed over, so it drops to zero whenever fetch is idle or served.
  always_comb begin
    fair_cnt_d = fair_cnt_q;
    if (!if_req || grant_if) begin
      fair_cnt_d = '0;
    end else if (grant_data && !fair_hit) begin
      fair_cnt_d = fair_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      fair_cnt_q  <= '0;
      slot_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_write_q <= 1'b0;
      mem_wdata_q <= '0;
      if_insn0_q  <= '0;
      ls0_done_q  <= 1'b0;
      ls1_done_q  <= 1'b0;
      if_done_q   <= 1'b0;
    end else begin
      // Done flags are single-cycle pulses unless re-armed below.
      ls0_done_q <= 1'b0;
      ls1_done_q <= 1'b0;
      if_done_q  <= 1'b0;
      fair_cnt_q <= fair_cnt_d;
      case (state_q)
        // Grant edge: the winner's command is registered toward the RAM.
        IDLE: begin
          if (grant_if) begin
            state_q     <= F0;
            mem_addr_q  <= if_addr;
            mem_write_q <= 1'b0;
          end else if (grant_data) begin
            state_q     <= ACC;
            slot_q      <= grant_ls1;
            mem_addr_q  <= grant_ls1 ? ls1_addr  : ls0_addr;
            mem_write_q <= grant_ls1 ? ls1_we    : ls0_we;
            mem_wdata_q <= grant_ls1 ? ls1_wdata : ls0_wdata;
          end
        end
        // Address cycle: the RAM samples the command; the write lasts one cycle.
        ACC: begin
          state_q     <= RESP;
          mem_write_q <= 1'b0;
          ls0_done_q  <= ~slot_q;
          ls1_done_q  <= slot_q;
        end
        // Response cycle: read data is on mem_rdata while done is high.
        RESP: begin
          state_q <= IDLE;
        end
        // Fetch word 0 address cycle; the second address wraps at 2^AW.
        F0: begin
          state_q    <= F1;
          mem_addr_q <= mem_addr_q + AW'(1);
        end
        // Word 0 arrives while word 1 is being addressed.
        F1: begin
          state_q    <= F2;
          if_insn0_q <= mem_rdata;
          if_done_q  <= 1'b1;
        end
        // Word 1 is presented straight from the RAM alongside if_done.
        F2: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_write  = mem_write_q;
  assign mem_wdata  = mem_wdata_q;
  assign ls0_done   = ls0_done_q;
  assign ls1_done   = ls1_done_q;
  assign if_done    = if_done_q;
  assign if_insn0   = if_insn0_q;
  assign if_insn1   = mem_rdata;
  assign ls0_rdata  = mem_rdata;
  assign ls1_rdata  = mem_rdata;
  assign pipe_stall = (ls0_req & ~ls0_done_q) | (ls1_req & ~ls1_done_q);

endmodule

// File: tb/tb_mem_port_sched.sv
`timescale 1ns/1ps
module tb_mem_port_sched;
  localparam int AW = 9;
  localparam int DW = 16;
  localparam int FAIR_MAX = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic [DW-1:0] if_insn0, if_insn1;
  logic          ls0_req, ls0_we, ls0_done;
  logic [AW-1:0] ls0_addr;
  logic [DW-1:0] ls0_wdata, ls0_rdata;
  logic          ls1_req, ls1_we, ls1_done;
  logic [AW-1:0] ls1_addr;
  logic [DW-1:0] ls1_wdata, ls1_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_write;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          pipe_stall;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [DW-1:0] ram [0:DEPTH-1] = '{default: '0};
  logic [DW-1:0] ref_mem [0:DEPTH-1];

  mem_port_sched #(.AW(AW), .DW(DW), .FAIR_MAX(FAIR_MAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .if_insn0(if_insn0), .if_insn1(if_insn1),
    .ls0_req(ls0_req), .ls0_we(ls0_we), .ls0_addr(ls0_addr), .ls0_wdata(ls0_wdata),
    .ls0_done(ls0_done), .ls0_rdata(ls0_rdata),
    .ls1_req(ls1_req), .ls1_we(ls1_we), .ls1_addr(ls1_addr), .ls1_wdata(ls1_wdata),
    .ls1_done(ls1_done), .ls1_rdata(ls1_rdata),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pipe_stall(pipe_stall)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM, read-before-write.
  always @(posedge clk) begin
    if (mem_write) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_ls(input bit slot, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, output int lat, output logic [DW-1:0] rd,
                        output int wr_cyc, output int stall_bad);
    lat = -1; rd = '0; wr_cyc = 0; stall_bad = 0;
    if (!slot) begin
      ls0_req = 1'b1; ls0_we = we; ls0_addr = a; ls0_wdata = wd;
    end else begin
      ls1_req = 1'b1; ls1_we = we; ls1_addr = a; ls1_wdata = wd;
    end
    #1;
    if (pipe_stall !== 1'b1) stall_bad++;
    for (int t = 1; t <= 12; t++) begin
      step();
      if (mem_write === 1'b1) wr_cyc++;
      if ((slot ? ls1_done : ls0_done) === 1'b1) begin
        lat = t;
        rd = slot ? ls1_rdata : ls0_rdata;
        if (slot) ls1_req = 1'b0; else ls0_req = 1'b0;
        #1;
        if (pipe_stall !== 1'b0) stall_bad++;
        break;
      end else if (pipe_stall !== 1'b1) begin
        stall_bad++;
      end
    end
    ls0_req = 1'b0; ls1_req = 1'b0;
    step();
  endtask

  task automatic run_fetch(input logic [AW-1:0] a, output int lat,
                           output logic [DW-1:0] i0, output logic [DW-1:0] i1, output int wr_cyc);
    lat = -1; i0 = '0; i1 = '0; wr_cyc = 0;
    if_req = 1'b1; if_addr = a;
    for (int t = 1; t <= 12; t++) begin
      step();
      if (mem_write === 1'b1) wr_cyc++;
      if (if_done === 1'b1) begin
        lat = t; i0 = if_insn0; i1 = if_insn1;
        break;
      end
    end
    if_req = 1'b0;
    step();
  endtask

  task automatic test_reset();
    ls0_req = 1'b1; ls0_we = 1'b1; ls0_addr = 9'h005; ls0_wdata = 16'h5555;
    step(); step(); step();
    chk_cnt++;
    if ({mem_write, mem_addr, mem_wdata} !== '0)
      $display("FAIL reset_cmd: got we=%b addr=%h wdata=%h want all zero", mem_write, mem_addr, mem_wdata);
    else pass_cnt++;
    chk_cnt++;
    if ({ls0_done, ls1_done, if_done} !== 3'b000)
      $display("FAIL reset_done: got %b want 000", {ls0_done, ls1_done, if_done});
    else pass_cnt++;
    chk_cnt++;
    if (if_insn0 !== '0) $display("FAIL reset_insn0: got %h want 0000", if_insn0);
    else pass_cnt++;
    reset = 1'b0;
    step();
    chk_cnt++;
    if (mem_write !== 1'b1 || mem_addr !== 9'h005 || mem_wdata !== 16'h5555)
      $display("FAIL reset_first_grant: got we=%b addr=%h wdata=%h want 1/005/5555", mem_write, mem_addr, mem_wdata);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (ls0_done !== 1'b1) $display("FAIL reset_first_done: got %b want 1", ls0_done);
    else pass_cnt++;
    ref_mem[9'h005] = 16'h5555;
    ls0_req = 1'b0;
    step();
  endtask

  task automatic test_store_load();
    int lat, wr, sb;
    logic [DW-1:0] rd;
    run_ls(1'b0, 1'b1, 9'h024, 16'h1234, lat, rd, wr, sb);
    ref_mem[9'h024] = 16'h1234;
    chk_cnt++;
    if (lat !== 2) $display("FAIL str_latency: got %0d want 2", lat); else pass_cnt++;
    chk_cnt++;
    if (wr !== 1) $display("FAIL str_write_cycles: got %0d want 1", wr); else pass_cnt++;
    chk_cnt++;
    if (sb !== 0) $display("FAIL str_stall: got %0d bad cycles want 0", sb); else pass_cnt++;
    run_ls(1'b1, 1'b0, 9'h024, 16'h0000, lat, rd, wr, sb);
    chk_cnt++;
    if (rd !== 16'h1234) $display("FAIL ldr_data: got %h want 1234", rd); else pass_cnt++;
    chk_cnt++;
    if (lat !== 2 || wr !== 0) $display("FAIL ldr_timing: got lat=%0d wr=%0d want 2/0", lat, wr); else pass_cnt++;
  endtask

  task automatic test_dual_issue();
    int t0 = -1, t1 = -1, sb = 0, gok = 0;
    logic [DW-1:0] rd0 = '0;
    logic [DW-1:0] wd = DW'($urandom);
    ls0_req = 1'b1; ls0_we = 1'b0; ls0_addr = 9'h010; ls0_wdata = '0;
    ls1_req = 1'b1; ls1_we = 1'b1; ls1_addr = 9'h020; ls1_wdata = wd;
    for (int t = 1; t <= 12; t++) begin
      step();
      if (t == 4 && mem_addr === 9'h020 && mem_write === 1'b1 && mem_wdata === wd) gok = 1;
      if (ls0_done === 1'b1) begin t0 = t; rd0 = ls0_rdata; ls0_req = 1'b0; end
      if (ls1_done === 1'b1) begin t1 = t; ls1_req = 1'b0; break; end
      #1;
      if (pipe_stall !== 1'b1) sb++;
    end
    ls0_req = 1'b0; ls1_req = 1'b0;
    chk_cnt++;
    if (t0 !== 2) $display("FAIL dual_ls0_done: got t=%0d want 2", t0); else pass_cnt++;
    chk_cnt++;
    if (rd0 !== ref_mem[9'h010]) $display("FAIL dual_ls0_data: got %h want %h", rd0, ref_mem[9'h010]); else pass_cnt++;
    chk_cnt++;
    if (gok !== 1) $display("FAIL dual_ls1_grant: got %0d want grant visible at t=4", gok); else pass_cnt++;
    chk_cnt++;
    if (t1 !== 5) $display("FAIL dual_ls1_done: got t=%0d want 5", t1); else pass_cnt++;
    chk_cnt++;
    if (sb !== 0) $display("FAIL dual_stall: got %0d low cycles want 0", sb); else pass_cnt++;
    ref_mem[9'h020] = wd;
    step();
  endtask

  task automatic test_fetch_wrap();
    int lat, wr, sb;
    logic [DW-1:0] rd, i0, i1;
    run_ls(1'b0, 1'b1, 9'h1FF, 16'hD102, lat, rd, wr, sb);
    run_ls(1'b0, 1'b1, 9'h000, 16'h6264, lat, rd, wr, sb);
    ref_mem[9'h1FF] = 16'hD102;
    ref_mem[9'h000] = 16'h6264;
    run_fetch(9'h1FF, lat, i0, i1, wr);
    chk_cnt++;
    if (lat !== 3) $display("FAIL fetch_latency: got %0d want 3", lat); else pass_cnt++;
    chk_cnt++;
    if (i0 !== 16'hD102) $display("FAIL fetch_insn0: got %h want d102", i0); else pass_cnt++;
    chk_cnt++;
    if (i1 !== 16'h6264) $display("FAIL fetch_insn1: got %h want 6264", i1); else pass_cnt++;
    chk_cnt++;
    if (wr !== 0) $display("FAIL fetch_no_write: got %0d write cycles want 0", wr); else pass_cnt++;
  endtask

  task automatic test_fairness();
    int data_cnt = 0, nf = 0, ls1_cnt = 0;
    int fcnt[2] = '{-1, -1};
    int fc_zero = 0;
    ls0_req = 1'b1; ls0_we = 1'b0; ls0_addr = AW'($urandom_range(0, 31));
    ls1_req = 1'b1; ls1_we = 1'b0; ls1_addr = AW'($urandom_range(0, 31));
    if_req = 1'b1; if_addr = 9'h030;
    for (int t = 1; t <= 80; t++) begin
      step();
      if (ls0_done === 1'b1 || ls1_done === 1'b1) data_cnt++;
      if (ls1_done === 1'b1) ls1_cnt++;
      if (if_done === 1'b1) begin
        fcnt[nf] = data_cnt;
        if (nf == 0 && dut.fair_cnt_q === '0) fc_zero = 1;
        nf++;
        data_cnt = 0;
        if (nf == 2) break;
      end
    end
    ls0_req = 1'b0; ls1_req = 1'b0; if_req = 1'b0;
    step(); step();
    chk_cnt++;
    if (nf !== 2) $display("FAIL fair_fetches: got %0d want 2", nf); else pass_cnt++;
    chk_cnt++;
    if (fcnt[0] !== FAIR_MAX) $display("FAIL fair_first: got %0d data grants want %0d", fcnt[0], FAIR_MAX); else pass_cnt++;
    chk_cnt++;
    if (fcnt[1] !== FAIR_MAX) $display("FAIL fair_second: got %0d data grants want %0d", fcnt[1], FAIR_MAX); else pass_cnt++;
    chk_cnt++;
    if (fc_zero !== 1) $display("FAIL fair_cnt_clear: got %0d want 1", fc_zero); else pass_cnt++;
    chk_cnt++;
    if (ls1_cnt !== 0) $display("FAIL fair_ls1_order: got %0d ls1 grants want 0", ls1_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid_store();
    ls0_req = 1'b1; ls0_we = 1'b1; ls0_addr = 9'h050; ls0_wdata = 16'hBEEF;
    step();
    chk_cnt++;
    if (mem_write !== 1'b1) $display("FAIL rst_acc_we: got %b want 1", mem_write); else pass_cnt++;
    reset = 1'b1;
    step();
    chk_cnt++;
    if (mem_write !== 1'b0 || ls0_done !== 1'b0)
      $display("FAIL rst_abort: got we=%b done=%b want 0/0", mem_write, ls0_done);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (mem_write !== 1'b0 || ls0_done !== 1'b0 || mem_addr !== '0)
      $display("FAIL rst_hold: got we=%b done=%b addr=%h want 0/0/000", mem_write, ls0_done, mem_addr);
    else pass_cnt++;
    reset = 1'b0;
    step();
    chk_cnt++;
    if (mem_write !== 1'b1 || mem_addr !== 9'h050)
      $display("FAIL rst_regrant: got we=%b addr=%h want 1/050", mem_write, mem_addr);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (ls0_done !== 1'b1) $display("FAIL rst_regrant_done: got %b want 1", ls0_done); else pass_cnt++;
    ls0_req = 1'b0;
    ref_mem[9'h050] = 16'hBEEF;
    step();
  endtask

  task automatic test_ls1_then_ls0();
    int t0 = -1, t1 = -1, ovl = 0;
    logic [DW-1:0] rd0 = '0, rd1 = '0;
    logic [AW-1:0] a0 = AW'($urandom_range(0, 31));
    logic [AW-1:0] a1 = 9'h050;
    ls1_req = 1'b1; ls1_we = 1'b0; ls1_addr = a1;
    step();
    ls0_req = 1'b1; ls0_we = 1'b0; ls0_addr = a0;
    for (int t = 2; t <= 12; t++) begin
      step();
      if (ls0_done === 1'b1 && ls1_done === 1'b1) ovl++;
      if (ls1_done === 1'b1) begin t1 = t; rd1 = ls1_rdata; ls1_req = 1'b0; end
      if (ls0_done === 1'b1) begin t0 = t; rd0 = ls0_rdata; ls0_req = 1'b0; break; end
    end
    ls0_req = 1'b0; ls1_req = 1'b0;
    chk_cnt++;
    if (t1 !== 2) $display("FAIL order_ls1_done: got t=%0d want 2", t1); else pass_cnt++;
    chk_cnt++;
    if (t0 !== 5) $display("FAIL order_ls0_done: got t=%0d want 5", t0); else pass_cnt++;
    chk_cnt++;
    if (rd1 !== ref_mem[a1] || rd0 !== ref_mem[a0])
      $display("FAIL order_data: got %h/%h want %h/%h", rd1, rd0, ref_mem[a1], ref_mem[a0]);
    else pass_cnt++;
    chk_cnt++;
    if (ovl !== 0) $display("FAIL order_overlap: got %0d want 0", ovl); else pass_cnt++;
    step();
  endtask

  task automatic test_drop();
    int t0 = -1, seen1 = 0, wr, sb, lat;
    logic [DW-1:0] rd;
    logic [DW-1:0] wd = DW'($urandom);
    logic [AW-1:0] a = AW'($urandom_range(32, 63));
    ls0_req = 1'b1; ls0_we = 1'b1; ls0_addr = a; ls0_wdata = wd;
    step();
    ls0_req = 1'b0;
    ls1_req = 1'b1; ls1_we = 1'b0; ls1_addr = a;
    for (int t = 2; t <= 9; t++) begin
      step();
      if (t == 2) ls1_req = 1'b0;
      if (ls0_done === 1'b1) t0 = t;
      if (ls1_done === 1'b1) seen1++;
    end
    ref_mem[a] = wd;
    chk_cnt++;
    if (t0 !== 2) $display("FAIL drop_after_grant: got t=%0d want 2", t0); else pass_cnt++;
    chk_cnt++;
    if (seen1 !== 0) $display("FAIL drop_before_grant: got %0d dones want 0", seen1); else pass_cnt++;
    run_ls(1'b1, 1'b0, a, '0, lat, rd, wr, sb);
    chk_cnt++;
    if (rd !== wd) $display("FAIL drop_store_kept: got %h want %h", rd, wd); else pass_cnt++;
  endtask

  task automatic test_random_mix();
    for (int r = 0; r < 40; r++) begin
      logic [2:0] mask, pend;
      bit we_r[2];
      logic [AW-1:0] a_r[2];
      logic [DW-1:0] wd_r[2];
      logic [AW-1:0] fa, fa1;
      int exp_t[3], obs_t[3];
      logic [DW-1:0] exp_d[2], obs_d[2], exp_i0, exp_i1, obs_i0, obs_i1;
      int td, cnt, w, ovl, nd;
      mask = 3'($urandom_range(1, 7));
      for (int s = 0; s < 2; s++) begin
        we_r[s] = 1'($urandom_range(0, 1));
        a_r[s] = AW'($urandom_range(0, 31));
        wd_r[s] = DW'($urandom);
        exp_d[s] = '0; obs_d[s] = '0;
      end
      fa = ($urandom_range(0, 3) == 0) ? 9'h1FF : AW'($urandom);
      fa1 = fa + 9'd1;
      exp_t = '{-1, -1, -1}; obs_t = '{-1, -1, -1};
      exp_i0 = '0; exp_i1 = '0; obs_i0 = '0; obs_i1 = '0;
      // Reference schedule: a data access occupies 3 cycles, a fetch 4.
      pend = mask; td = 0; cnt = 0;
      while (pend != 3'b000) begin
        if (pend[2] && cnt == FAIR_MAX) w = 2;
        else if (pend[0]) w = 0;
        else if (pend[1]) w = 1;
        else w = 2;
        if (w == 2) begin
          cnt = 0;
          exp_t[2] = td + 3;
          exp_i0 = ref_mem[fa];
          exp_i1 = ref_mem[fa1];
          td += 4;
        end else begin
          cnt = pend[2] ? ((cnt < FAIR_MAX) ? cnt + 1 : cnt) : 0;
          exp_t[w] = td + 2;
          if (we_r[w]) ref_mem[a_r[w]] = wd_r[w];
          else exp_d[w] = ref_mem[a_r[w]];
          td += 3;
        end
        pend[w] = 1'b0;
      end
      if (mask[0]) begin ls0_req = 1'b1; ls0_we = we_r[0]; ls0_addr = a_r[0]; ls0_wdata = wd_r[0]; end
      if (mask[1]) begin ls1_req = 1'b1; ls1_we = we_r[1]; ls1_addr = a_r[1]; ls1_wdata = wd_r[1]; end
      if (mask[2]) begin if_req = 1'b1; if_addr = fa; end
      ovl = 0;
      for (int t = 1; t <= 30; t++) begin
        step();
        nd = int'(ls0_done === 1'b1) + int'(ls1_done === 1'b1) + int'(if_done === 1'b1);
        if (nd > 1) ovl++;
        if (ls0_done === 1'b1) begin obs_t[0] = t; obs_d[0] = ls0_rdata; ls0_req = 1'b0; end
        if (ls1_done === 1'b1) begin obs_t[1] = t; obs_d[1] = ls1_rdata; ls1_req = 1'b0; end
        if (if_done === 1'b1) begin obs_t[2] = t; obs_i0 = if_insn0; obs_i1 = if_insn1; if_req = 1'b0; end
        if ((!mask[0] || obs_t[0] >= 0) && (!mask[1] || obs_t[1] >= 0) && (!mask[2] || obs_t[2] >= 0)) break;
      end
      ls0_req = 1'b0; ls1_req = 1'b0; if_req = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (mask[k]) begin
          chk_cnt++;
          if (obs_t[k] !== exp_t[k])
            $display("FAIL rand_time r%0d port%0d: got t=%0d want t=%0d", r, k, obs_t[k], exp_t[k]);
          else pass_cnt++;
        end
      end
      for (int s = 0; s < 2; s++) begin
        if (mask[s] && !we_r[s]) begin
          chk_cnt++;
          if (obs_d[s] !== exp_d[s])
            $display("FAIL rand_load r%0d ls%0d: got %h want %h", r, s, obs_d[s], exp_d[s]);
          else pass_cnt++;
        end
      end
      if (mask[2]) begin
        chk_cnt++;
        if (obs_i0 !== exp_i0 || obs_i1 !== exp_i1)
          $display("FAIL rand_fetch r%0d: got %h/%h want %h/%h", r, obs_i0, obs_i1, exp_i0, exp_i1);
        else pass_cnt++;
      end
      chk_cnt++;
      if (ovl !== 0) $display("FAIL rand_overlap r%0d: got %0d want 0", r, ovl); else pass_cnt++;
      for (int g = 0; g < int'($urandom_range(1, 3)); g++) step();
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    ls0_req = 1'b0; ls0_we = 1'b0; ls0_addr = '0; ls0_wdata = '0;
    ls1_req = 1'b0; ls1_we = 1'b0; ls1_addr = '0; ls1_wdata = '0;
    test_reset();
    test_store_load();
    test_dual_issue();
    test_fetch_wrap();
    test_fairness();
    test_reset_mid_store();
    test_ls1_then_ls0();
    test_drop();
    test_random_mix();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
